player_input_ctrl: RTL
======================

Name: player_input_ctrl

Overview:
- Sits between the SoC keycode PIO and one `player` instance. One instance per player.
- Samples that player's 8-bit keycode once per video frame and decodes it against the player's 6-key control map.
- Produces frame-stable movement/aim levels and a charge-and-release bomb launch with a power value.
- Replaces raw per-cycle keycode decoding inside `player`; the fire input gains charge, cooldown and one-shot semantics.

Parameters:
- POWER_W, 6, width of fire_power.
- MAX_POWER, 63, saturation value of the charge counter (must be < 2^POWER_W).
- COOLDOWN_FRAMES, 30, frames after a launch during which fire is ignored.

Ports:
- clk  input  1  system clock (CLOCK_50)
- reset_n  input  1  asynchronous, active-low reset
- frame_clk  input  1  VGA vertical sync (VGA_VS), asynchronous to clk, idle high
- keycode  input  8  this player's keycode from the SoC; 8'h00 = no key
- controls  input  48  key map {up,down,left,right,fire,special}, up in [47:40] … special in [7:0]
- frame_tick  output  1  one-clk pulse per frame
- up, down, left, right, special  output  1 each  held-key levels, constant for a whole frame
- charging  output  1  high while in CHARGE
- fire_power  output  POWER_W  power of the last launch, held until the next launch
- fire_strobe  output  1  one-clk launch pulse, fire_power valid in the same cycle

Behaviour:
- **Reset values:** async reset_n=0 clears every output to 0, sets state=IDLE, power=0, cooldown=0, prev_fire=0. Both frame_clk sync flops reset to 1, so no spurious tick is produced after reset.
- **Frame tick:**
  - frame_clk passes through a 2-flop synchronizer plus an edge register.
  - frame_tick=1 for exactly one clk when the synchronized value goes 1→0.
  - Latency is 3 clk after the frame_clk falling edge.
- **Keycode sampling:** keycode is sampled only in the frame_tick cycle (it is already in the clk domain). Changes between ticks are ignored.
- **Level decode:**
  - On a tick, each level output is registered as (keycode == its control byte).
  - Outputs update the clk after the tick and are held until the next tick.
  - keycode 8'h00 or an unmapped code gives all levels 0.
  - A control byte of 8'h00 never matches.
- **fire_now:** (keycode == controls[15:8]) in the tick cycle. prev_fire <= fire_now on every tick.
- **FSM** (advances only on ticks):
  - IDLE: if fire_now && !prev_fire → CHARGE, power<=1. A key held across IDLE entry does not re-arm; it must be released and pressed again.
  - CHARGE: if fire_now → power <= min(power+1, MAX_POWER), saturating. Else → FIRE.
  - FIRE (lasts one clk): fire_strobe=1, fire_power<=power, cooldown<=COOLDOWN_FRAMES → COOLDOWN.
  - COOLDOWN: decrement cooldown each tick; fire is ignored. When cooldown reaches 0 → IDLE. With COOLDOWN_FRAMES=0 the FSM enters IDLE on the first tick after FIRE.
- **charging** = (state==CHARGE), registered.
- **Strobe timing:** fire_strobe occurs exactly 1 clk after the tick on which release was seen. It is never asserted on two consecutive cycles.
- **Mid-operation reset:** reset during CHARGE or COOLDOWN aborts immediately. No strobe is produced; fire_power returns to 0.
- **Simultaneous events:** a tick that coincides with reset deassertion is ignored, because the sync flops are still 1.

Optional Feature:
- Macro: PLAYER_INPUT_AUTOFIRE_EN.
- **Defined:** in CHARGE, on the tick where power is already MAX_POWER and fire is still held → FIRE with power=MAX_POWER. The player must release and re-press to charge again.
- **Undefined:** power saturates at MAX_POWER and holds until release.

Test Plan:
1. **Reset / no tick:** reset_n low, frame_clk=1, keycode=8'h1A → all outputs 0. Release reset → no frame_tick until the first frame_clk falling edge; frame_tick appears exactly 3 clk after that edge.
2. **Level decode:** controls=P1 map (W=26,S=22,A=04,D=07,Q=20,E=08), keycode=8'h04 at a tick → left=1 from tick+1 for a full frame. Changing keycode to 8'h07 mid-frame has no effect until the next tick.
3. **Charge/launch:** hold Q (8'h14) for 5 ticks, then 8'h00 at the next tick → charging=1 across the held ticks. Single fire_strobe 1 clk after the release tick, fire_power=5.
4. **Saturation:** MAX_POWER=63, hold Q for 80 ticks, then release → fire_power=63 with the macro undefined. With PLAYER_INPUT_AUTOFIRE_EN defined, the strobe occurs on tick 64 with power 63.
5. **Cooldown:** after a launch, press Q within 30 ticks → no CHARGE, no strobe. Release and press on tick 31 or later → CHARGE entered. A Q held continuously through the cooldown must not start a charge.
6. **Abort:** reset_n pulsed low for 2 clk during CHARGE (power=10) → no strobe, fire_power=0, state IDLE.

Source files
------------

// File: rtl/player_input_ctrl.sv
// player_input_ctrl
//   Per-player front end between the SoC keycode PIO and one `player`.
//   Once per video frame it samples the player's keycode, decodes it against
//   the 6-key control map into frame-stable levels, and runs a charge-and-
//   release bomb launcher (charge, saturate, launch strobe, cooldown).
//
//   Optional build macro: PLAYER_INPUT_AUTOFIRE_EN
//     defined   : holding fire at MAX_POWER for one more frame launches at MAX_POWER
//     undefined : power saturates at MAX_POWER and waits for release
//
// Ports
//   clk         system clock (CLOCK_50)
//   reset_n     asynchronous active-low reset
//   frame_clk   VGA vertical sync, asynchronous to clk, idle high
//   keycode     this player's keycode, 8'h00 = no key
//   controls    key map {up,down,left,right,fire,special}, 8 bits each, up in [47:40]
//   frame_tick  one-clk pulse per frame (3 clk after frame_clk falls)
//   up/down/left/right/special  held-key levels, constant for a whole frame
//   charging    high while charging
//   fire_power  power of the last launch, held until the next launch
//   fire_strobe one-clk launch pulse, fire_power valid in the same cycle
module player_input_ctrl #(
  parameter int POWER_W         = 6,
  parameter int MAX_POWER       = 63,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_clk,
  input  logic [7:0]         keycode,
  input  logic [47:0]        controls,
  output logic               frame_tick,
  output logic               up,
  output logic               down,
  output logic               left,
  output logic               right,
  output logic               special,
  output logic               charging,
  output logic [POWER_W-1:0] fire_power,
  output logic               fire_strobe
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CHARGE = 2'd1;
  localparam logic [1:0] S_FIRE   = 2'd2;
  localparam logic [1:0] S_COOL   = 2'd3;

  localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CD_W-1:0]    CD_INIT = CD_W'(COOLDOWN_FRAMES);
  localparam logic [POWER_W-1:0] MAX_P   = POWER_W'(MAX_POWER);

`ifdef PLAYER_INPUT_AUTOFIRE_EN
  localparam bit AUTOFIRE = 1'b1;
`else
  localparam bit AUTOFIRE = 1'b0;
`endif

  // An unassigned (zero) control byte must never match, including keycode 8'h00.
  function automatic logic key_match(input logic [7:0] code, input logic [7:0] ctl);
    return (ctl != 8'h00) && (code == ctl);
  endfunction

  function automatic logic [POWER_W-1:0] sat_inc(input logic [POWER_W-1:0] p);
    return (p >= MAX_P) ? MAX_P : p + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: edge register.
  // All three reset high so a reset release never looks like a falling edge.
  logic fs_p0, fs_p1, fs_p2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fs_p0      <= 1'b1;
      fs_p1      <= 1'b1;
      fs_p2      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      fs_p0      <= frame_clk;
      fs_p1      <= fs_p0;
      fs_p2      <= fs_p1;
      frame_tick <= fs_p2 & ~fs_p1;
    end
  end

  // Level decode: keycode is only looked at in the frame_tick cycle.
  logic fire_now;
  logic prev_fire;

  assign fire_now = key_match(keycode, controls[15:8]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up        <= 1'b0;
      down      <= 1'b0;
      left      <= 1'b0;
      right     <= 1'b0;
      special   <= 1'b0;
      prev_fire <= 1'b0;
    end else if (frame_tick) begin
      up        <= key_match(keycode, controls[47:40]);
      down      <= key_match(keycode, controls[39:32]);
      left      <= key_match(keycode, controls[31:24]);
      right     <= key_match(keycode, controls[23:16]);
      special   <= key_match(keycode, controls[7:0]);
      prev_fire <= fire_now;
    end
  end

  // Launcher FSM: IDLE/CHARGE/COOL move on ticks only, FIRE is one clk.
  logic [1:0]         state, state_nxt;
  logic [POWER_W-1:0] power, power_nxt;
  logic [CD_W-1:0]    cooldown, cooldown_nxt;
  logic [POWER_W-1:0] fire_power_nxt;
  logic               fire_strobe_nxt;

  always_comb begin
    state_nxt       = state;
    power_nxt       = power;
    cooldown_nxt    = cooldown;
    fire_power_nxt  = fire_power;
    fire_strobe_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        // Rising fire only: a key still held from before must be released first.
        if (frame_tick && fire_now && !prev_fire) begin
          state_nxt = S_CHARGE;
          power_nxt = POWER_W'(1);
        end
      end
      S_CHARGE: begin
        if (frame_tick) begin
          if (fire_now && !(AUTOFIRE && (power == MAX_P))) begin
            power_nxt = sat_inc(power);
          end else begin
            // Strobe is registered here so it lands in the FIRE cycle,
            // exactly one clk after the release tick.
            state_nxt       = S_FIRE;
            fire_strobe_nxt = 1'b1;
            fire_power_nxt  = power;
          end
        end
      end
      S_FIRE: begin
        state_nxt    = S_COOL;
        cooldown_nxt = CD_INIT;
      end
      default: begin
        // Leaving on the tick that consumes the last frame makes the
        // COOLDOWN_FRAMES-th tick the last ignored one; 0 exits on the first.
        if (frame_tick) begin
          if (cooldown <= CD_W'(1)) begin
            state_nxt    = S_IDLE;
            cooldown_nxt = '0;
          end else begin
            cooldown_nxt = cooldown - 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      power       <= '0;
      cooldown    <= '0;
      fire_power  <= '0;
      fire_strobe <= 1'b0;
      charging    <= 1'b0;
    end else begin
      state       <= state_nxt;
      power       <= power_nxt;
      cooldown    <= cooldown_nxt;
      fire_power  <= fire_power_nxt;
      fire_strobe <= fire_strobe_nxt;
      charging    <= (state_nxt == S_CHARGE);
    end
  end

endmodule
